// File: rtl/adder_pkg.sv
// Shared definitions for the pipelined adder: operating-mode encodings and the
// stage-count helper used to size the pipeline at elaboration.
package adder_pkg;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    // Returns 0 for an illegal split so the caller can flag it at elaboration.
    function automatic int calc_stages(input int width, input int segment);
        if (segment < 1 || width < segment || (width % segment) != 0) begin
            return 0;
        end
        return width / segment;
    endfunction

endpackage

// File: rtl/pipelined_adder_nb_if.sv
// Operand/result handshake bundle for the pipelined adder. The slave modport
// is the adder's view; master is the view of the block driving it.
interface pipelined_adder_nb_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
endinterface

// File: rtl/adder_segment.sv
// One pipeline slice: a SEGMENT-bit ripple of full adders. Also exposes the
// carry into the slice MSB so the last stage can derive signed overflow.
module full_adder_1b (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic c_o
);
    assign s_o = a_i ^ b_i ^ c_i;
    assign c_o = (a_i & b_i) | (c_i & (a_i ^ b_i));
endmodule

module adder_segment #(
    parameter int SEGMENT = 8
) (
    input  logic [SEGMENT-1:0] a_i,
    input  logic [SEGMENT-1:0] b_i,
    input  logic               c_i,
    output logic [SEGMENT-1:0] sum_o,
    output logic               cout_o,
    output logic               cmsb_o
);
    logic [SEGMENT:0] carry;

    assign carry[0] = c_i;

    for (genvar i = 0; i < SEGMENT; i++) begin : g_bit
        full_adder_1b u_fa (
            .a_i (a_i[i]),
            .b_i (b_i[i]),
            .c_i (carry[i]),
            .s_o (sum_o[i]),
            .c_o (carry[i+1])
        );
    end

    assign cout_o = carry[SEGMENT];
    assign cmsb_o = carry[SEGMENT-1];
endmodule

// File: rtl/pipelined_adder_nb.sv
// Pipelined WIDTH-bit adder/subtractor: one SEGMENT-bit slice resolved per
// stage, carry registered between stages, valid/ready on both sides.
module pipelined_adder_nb
    import adder_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SEGMENT = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    pipelined_adder_nb_if.slave  bus
);
    localparam int STAGES_RAW = calc_stages(WIDTH, SEGMENT);
    localparam int STAGES     = (STAGES_RAW < 1) ? 1 : STAGES_RAW;
    localparam int LAST       = STAGES - 1;

    if (STAGES_RAW < 1) begin : g_bad_cfg
        $error("pipelined_adder_nb: WIDTH must be a positive multiple of SEGMENT");
    end

    logic [WIDTH-1:0]   a_q     [STAGES];
    logic [WIDTH-1:0]   b_q     [STAGES];
    logic [WIDTH-1:0]   s_q     [STAGES];
    logic               carry_q [STAGES];
    logic [STAGES-1:0]  v_q;
    logic               cmsb_q;

    logic [WIDTH-1:0]   a_in    [STAGES];
    logic [WIDTH-1:0]   b_in    [STAGES];
    logic [WIDTH-1:0]   s_in    [STAGES];
    logic               c_in    [STAGES];
    logic [STAGES-1:0]  v_in;
    logic [WIDTH-1:0]   s_d     [STAGES];
    logic [SEGMENT-1:0] seg_sum [STAGES];
    logic               seg_cout[STAGES];
    logic               seg_cmsb[STAGES];
    logic [STAGES-1:0]  adv;

    logic [WIDTH-1:0]   b_eff;
    logic               c_init;

    assign b_eff  = (bus.sub == MODE_ADD) ? bus.b : ~bus.b;
    assign c_init = (bus.sub == MODE_SUB) ? 1'b1 : bus.cin;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam logic [WIDTH-1:0] SLICE_MASK = WIDTH'({SEGMENT{1'b1}}) << (k * SEGMENT);

        if (k == 0) begin : g_head
            assign a_in[k] = bus.a;
            assign b_in[k] = b_eff;
            assign s_in[k] = '0;
            assign c_in[k] = c_init;
            assign v_in[k] = bus.in_valid;
        end else begin : g_body
            assign a_in[k] = a_q[k-1];
            assign b_in[k] = b_q[k-1];
            assign s_in[k] = s_q[k-1];
            assign c_in[k] = carry_q[k-1];
            assign v_in[k] = v_q[k-1];
        end

        adder_segment #(.SEGMENT(SEGMENT)) u_seg (
            .a_i    (a_in[k][k*SEGMENT +: SEGMENT]),
            .b_i    (b_in[k][k*SEGMENT +: SEGMENT]),
            .c_i    (c_in[k]),
            .sum_o  (seg_sum[k]),
            .cout_o (seg_cout[k]),
            .cmsb_o (seg_cmsb[k])
        );

        assign s_d[k] = (s_in[k] & ~SLICE_MASK) | (WIDTH'(seg_sum[k]) << (k * SEGMENT));
    end

    // A stage may load if it is empty or its own content moves on this cycle,
    // so any bubble downstream lets everything behind it advance.
    always_comb begin
        adv       = '0;
        adv[LAST] = !v_q[LAST] || bus.out_ready;
        for (int k = LAST - 1; k >= 0; k--) begin
            adv[k] = !v_q[k] || adv[k+1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v_q    <= '0;
            cmsb_q <= 1'b0;
            for (int k = 0; k < STAGES; k++) begin
                a_q[k]     <= '0;
                b_q[k]     <= '0;
                s_q[k]     <= '0;
                carry_q[k] <= 1'b0;
            end
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (adv[k]) begin
                    v_q[k]     <= v_in[k];
                    a_q[k]     <= a_in[k];
                    b_q[k]     <= b_in[k];
                    s_q[k]     <= s_d[k];
                    carry_q[k] <= seg_cout[k];
                end
            end
            if (adv[LAST]) begin
                cmsb_q <= seg_cmsb[LAST];
            end
        end
    end

    assign bus.in_ready  = adv[0];
    assign bus.out_valid = v_q[LAST];
    assign bus.sum       = s_q[LAST];
    assign bus.cout      = carry_q[LAST];
    assign bus.ovf       = cmsb_q ^ carry_q[LAST];

endmodule
